// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: memory read channel, IR handoff to decode, and PC/status outputs.
interface instruction_fetch_unit_if;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemRdy;
  logic [31:0] MemData;
  logic [31:0] IR31_0;
  logic        IRValid;
  logic        IRAccept;
  logic        BrTaken;
  logic        BrAnnul;
  logic [31:0] BrDisp;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic        Misaligned;
  logic [31:0] InstrCount;

  modport master (
    output MemReq, MemAddr, IR31_0, IRValid, PC, nPC, Misaligned, InstrCount,
    input  MemRdy, MemData, IRAccept, BrTaken, BrAnnul, BrDisp
  );

  modport slave (
    input  MemReq, MemAddr, IR31_0, IRValid, PC, nPC, Misaligned, InstrCount,
    output MemRdy, MemData, IRAccept, BrTaken, BrAnnul, BrDisp
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch with delayed-branch PC/nPC pair and
// sticky misaligned-target trap.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                      Clk,
  input logic                      Reset,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, npc_q, npc_d, ir_q, ir_d, cnt_q, cnt_d;
  logic [31:0] tgt;

  assign tgt = pc_q + bus.BrDisp;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + 32'd4;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (bus.MemRdy) begin
        ir_d    = bus.MemData;
        state_d = HOLD;
      end
      HOLD:  if (bus.IRAccept) begin
        if (bus.BrTaken && (bus.BrDisp[1:0] != 2'b00)) begin
          // Bad target traps before anything architectural moves.
          state_d = ERR;
        end else begin
          state_d = FETCH;
          cnt_d   = cnt_q + 32'd1;
          if (!bus.BrTaken) begin
            pc_d  = npc_q;
            npc_d = npc_q + 32'd4;
          end else if (!bus.BrAnnul) begin
            pc_d  = npc_q;
            npc_d = tgt;
          end else begin
            pc_d  = tgt;
            npc_d = tgt + 32'd4;
          end
        end
      end
      ERR:   state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign bus.MemReq     = (state_q == FETCH);
  assign bus.MemAddr    = pc_q;
  assign bus.IRValid    = (state_q == HOLD);
  assign bus.Misaligned = (state_q == ERR);
  assign bus.IR31_0     = ir_q;
  assign bus.PC         = pc_q;
  assign bus.nPC        = npc_q;
  assign bus.InstrCount = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: table of fetch/accept records plus hand-written
// branch, wrap, trap and reset-collision sequences, with an IR scoreboard.
module tb_instruction_fetch_unit;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit #(.RESET_PC(32'h0)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          wait_cyc;
    int          hold_cyc;
    logic        taken;
    logic        annul;
    logic [31:0] disp;
    logic [31:0] exp_pc;
    logic [31:0] exp_npc;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] npc;
  } sb_t;

  vec_t        vecs[7];
  sb_t         sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_pc, m_npc, m_cnt;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs;
    bus.MemRdy   = 1'b0;
    bus.MemData  = 32'h0;
    bus.IRAccept = 1'b0;
    bus.BrTaken  = 1'b0;
    bus.BrAnnul  = 1'b0;
    bus.BrDisp   = 32'h0;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_pc  = 32'h0;
    m_npc = 32'h4;
    m_cnt = 32'h0;
    sb.delete();
    check("rst_memreq", bus.MemReq, 0);
    check("rst_irvalid", bus.IRValid, 0);
    check("rst_misaligned", bus.Misaligned, 0);
    check("rst_pc", bus.PC, 32'h0);
    check("rst_npc", bus.nPC, 32'h4);
    check("rst_ir", bus.IR31_0, 32'h0);
    check("rst_count", bus.InstrCount, 32'h0);
  endtask

  task automatic wait_fetch;
    int n = 0;
    while (bus.MemReq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("fetch_timeout", bus.MemReq, 1);
  endtask

  task automatic do_fetch(input logic [31:0] data, input int wait_cyc);
    sb_t e;
    wait_fetch();
    sb.push_back('{data, m_pc, m_npc});
    check("memaddr", bus.MemAddr, m_pc);
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      check("memreq_held", bus.MemReq, 1);
      check("memaddr_held", bus.MemAddr, m_pc);
    end
    bus.MemRdy  = 1'b1;
    bus.MemData = data;
    tick();
    bus.MemRdy  = 1'b0;
    bus.MemData = 32'hA5A5_A5A5;
    check("irvalid", bus.IRValid, 1);
    check("memreq_off", bus.MemReq, 0);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_empty: got IRValid expected no output");
    end else begin
      e = sb.pop_front();
      check("ir", bus.IR31_0, e.ir);
      check("hold_pc", bus.PC, e.pc);
      check("hold_npc", bus.nPC, e.npc);
    end
  endtask

  task automatic stall(input int n, input logic [31:0] ir);
    for (int i = 0; i < n; i++) begin
      bus.MemRdy   = 1'b1;
      bus.MemData  = 32'hDEAD_BEEF;
      bus.BrTaken  = 1'b1;
      bus.BrAnnul  = 1'b1;
      bus.BrDisp   = 32'h42;
      bus.IRAccept = 1'b0;
      tick();
      check("stall_ir", bus.IR31_0, ir);
      check("stall_irvalid", bus.IRValid, 1);
      check("stall_pc", bus.PC, m_pc);
      check("stall_npc", bus.nPC, m_npc);
      check("stall_mis", bus.Misaligned, 0);
    end
    clear_inputs();
  endtask

  task automatic do_accept(input logic taken, input logic annul, input logic [31:0] disp,
                           input logic [31:0] exp_pc, input logic [31:0] exp_npc);
    bus.IRAccept = 1'b1;
    bus.BrTaken  = taken;
    bus.BrAnnul  = annul;
    bus.BrDisp   = disp;
    tick();
    clear_inputs();
    m_pc  = exp_pc;
    m_npc = exp_npc;
    m_cnt = m_cnt + 32'd1;
    check("acc_irvalid", bus.IRValid, 0);
    check("acc_pc", bus.PC, exp_pc);
    check("acc_npc", bus.nPC, exp_npc);
    check("acc_count", bus.InstrCount, m_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h8200_6005, 1, 0, 1'b0, 1'b0, 32'h0,         32'h04, 32'h08};
    vecs[1] = '{32'h1111_0001, 0, 0, 1'b0, 1'b0, 32'h0,         32'h08, 32'h0C};
    vecs[2] = '{32'h2222_0002, 2, 5, 1'b0, 1'b0, 32'h0,         32'h0C, 32'h10};
    vecs[3] = '{32'h3333_0003, 0, 0, 1'b1, 1'b0, 32'h40,        32'h10, 32'h4C};
    vecs[4] = '{32'h4444_0004, 0, 1, 1'b0, 1'b1, 32'h13,        32'h4C, 32'h50};
    vecs[5] = '{32'h5555_0005, 1, 0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h44, 32'h48};
    vecs[6] = '{32'h6666_0006, 0, 0, 1'b0, 1'b0, 32'h0,         32'h48, 32'h4C};

    clear_inputs();
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) begin
      do_fetch(vecs[i].data, vecs[i].wait_cyc);
      stall(vecs[i].hold_cyc, vecs[i].data);
      do_accept(vecs[i].taken, vecs[i].annul, vecs[i].disp, vecs[i].exp_pc, vecs[i].exp_npc);
      if (i == 2) check("count_after_3", bus.InstrCount, 32'd3);
    end

    // Taken branch from 0x100, delay slot kept.
    do_reset();
    do_fetch(32'h0100_0000, 0);
    do_accept(1'b1, 1'b1, 32'h100, 32'h100, 32'h104);
    do_fetch(32'h0200_0000, 0);
    do_accept(1'b1, 1'b0, 32'h40, 32'h104, 32'h140);

    // Same branch with the delay slot annulled.
    do_reset();
    do_fetch(32'h0100_0000, 0);
    do_accept(1'b1, 1'b1, 32'h100, 32'h100, 32'h104);
    do_fetch(32'h0300_0000, 0);
    do_accept(1'b1, 1'b1, 32'h40, 32'h140, 32'h144);

    // Address wrap at the top of the 32-bit space.
    do_reset();
    do_fetch(32'h0400_0000, 0);
    do_accept(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
    do_fetch(32'h0500_0000, 0);
    do_accept(1'b0, 1'b0, 32'h0, 32'h0, 32'h4);

    // Misaligned target traps and stays trapped until reset.
    do_reset();
    do_fetch(32'h0600_0000, 0);
    do_accept(1'b0, 1'b0, 32'h0, 32'h4, 32'h8);
    do_fetch(32'h0700_0000, 0);
    bus.IRAccept = 1'b1;
    bus.BrTaken  = 1'b1;
    bus.BrDisp   = 32'h42;
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check("err_mis", bus.Misaligned, 1);
      check("err_memreq", bus.MemReq, 0);
      check("err_irvalid", bus.IRValid, 0);
      check("err_pc", bus.PC, 32'h4);
      check("err_npc", bus.nPC, 32'h8);
      check("err_count", bus.InstrCount, 32'd1);
      check("err_ir", bus.IR31_0, 32'h0700_0000);
      bus.MemRdy   = 1'b1;
      bus.MemData  = 32'hBAD0_BAD0;
      bus.IRAccept = 1'b1;
      tick();
      clear_inputs();
    end
    do_reset();

    // Reset colliding with MemRdy in FETCH, then a stray MemRdy in IDLE.
    do_fetch(32'h0800_0000, 0);
    do_accept(1'b0, 1'b0, 32'h0, 32'h4, 32'h8);
    wait_fetch();
    bus.MemRdy  = 1'b1;
    bus.MemData = 32'hCAFE_F00D;
    Reset       = 1'b1;
    tick();
    Reset = 1'b0;
    check("rstcol_irvalid", bus.IRValid, 0);
    check("rstcol_pc", bus.PC, 32'h0);
    check("rstcol_ir", bus.IR31_0, 32'h0);
    check("rstcol_count", bus.InstrCount, 32'h0);
    tick();
    clear_inputs();
    check("idle_rdy_irvalid", bus.IRValid, 0);
    check("idle_rdy_ir", bus.IR31_0, 32'h0);
    check("idle_rdy_memreq", bus.MemReq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
REQ-002 SHALL have port: Clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: MemReq  out  1  instruction read request to memory.
REQ-005 SHALL have port: MemAddr  out  32  read address; equals PC.
REQ-006 SHALL have port: MemRdy  in  1  memory data valid, one-cycle pulse.
REQ-007 SHALL have port: MemData  in  32  instruction word; valid when MemRdy=1.
REQ-008 SHALL have port: IR31_0  out  32  latched instruction word to decode and shifter/sign-extender.
REQ-009 SHALL have port: IRValid  out  1  IR31_0 holds an unconsumed instruction.
REQ-010 SHALL have port: IRAccept  in  1  decode consumes IR31_0 this cycle.
REQ-011 SHALL have port: BrTaken  in  1  consumed instruction is a taken control transfer; sampled only with accept.
REQ-012 SHALL have port: BrAnnul  in  1  annul delay slot of taken transfer; sampled only with accept.
REQ-013 SHALL have port: BrDisp  in  32  sign-extended, pre-shifted byte displacement from shifter/sign-extender.
REQ-014 SHALL have port: PC  out  32  address of the instruction in IR31_0 / being fetched.
REQ-015 SHALL have port: nPC  out  32  next PC.
REQ-016 SHALL have port: Misaligned  out  1  sticky misaligned-target error.
REQ-017 SHALL have port: InstrCount  out  32  count of accepted instructions.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD, ERR; all outputs registered or Moore-decoded from state.
REQ-019 SHALL transition IDLE -> FETCH unconditionally after one cycle.
REQ-020 SHALL assert MemReq=1 only in FETCH; MemAddr=PC, held stable throughout FETCH.
REQ-021 SHALL, in FETCH with MemRdy=1, load IR31_0<=MemData and go to HOLD; IRValid=1 the next cycle (one-cycle latency).
REQ-022 SHALL ignore MemRdy in IDLE, HOLD and ERR; IR31_0 unchanged.
REQ-023 SHALL assert IRValid=1 only in HOLD; IR31_0, PC, nPC stable while IRAccept=0.
REQ-024 SHALL, in HOLD with IRAccept=1 and BrTaken=0: PC<=nPC, nPC<=nPC+4, go to FETCH.
REQ-025 SHALL, on accept with BrTaken=1, BrAnnul=0: PC<=nPC (delay slot), nPC<=PC+BrDisp, go to FETCH.
REQ-026 SHALL, on accept with BrTaken=1, BrAnnul=1: PC<=PC+BrDisp, nPC<=PC+BrDisp+4 (delay slot skipped), go to FETCH.
REQ-027 SHALL ignore BrAnnul when BrTaken=0, and ignore BrTaken/BrAnnul/BrDisp without IRValid&IRAccept.
REQ-028 SHALL, on accept with BrTaken=1 and BrDisp[1:0]!=0: go to ERR, Misaligned<=1, PC/nPC unchanged, InstrCount not incremented.
REQ-029 SHALL hold ERR (MemReq=0, IRValid=0, Misaligned=1) until Reset.
REQ-030 SHALL increment InstrCount by 1 on every successful accept; wraps 32'hFFFF_FFFF -> 0.
REQ-031 SHALL compute all PC/nPC arithmetic modulo 2^32 (0xFFFF_FFFC+4 = 0).
REQ-032 SHALL sustain at most one outstanding fetch; max throughput one instruction per 2 cycles.

Reset
REQ-033 SHALL, on Reset=1 at a rising edge, set state=IDLE, PC=RESET_PC, nPC=RESET_PC+4, IR31_0=0, IRValid=0, MemReq=0, Misaligned=0, InstrCount=0.
REQ-034 SHALL give Reset priority over all simultaneous events (MemRdy, IRAccept, branch), including mid-fetch and in ERR.
REQ-035 SHALL drop any in-flight fetch on reset; MemRdy arriving after reset outside FETCH is ignored.

Verification
REQ-036 SHALL cover: reset, then MemRdy with MemData=32'h8200_6005 on 2nd FETCH cycle -> IRValid=1 next cycle, IR31_0=32'h8200_6005, PC=0.
REQ-037 SHALL cover: three sequential accepts, no branch -> PC 0,4,8,12; InstrCount=3; nPC=PC+4 throughout.
REQ-038 SHALL cover: accept at PC=0x100, nPC=0x104, BrTaken=1, BrDisp=0x40 -> PC=0x104, nPC=0x140; with BrAnnul=1 -> PC=0x140, nPC=0x144.
REQ-039 SHALL cover: accept with BrTaken=1, BrDisp=0x42 -> Misaligned=1, MemReq=0, IRValid=0, PC/nPC unchanged until Reset.
REQ-040 SHALL cover: IRAccept held 0 for 5 cycles in HOLD, MemRdy pulsed meanwhile -> IR31_0 unchanged, no state change.
REQ-041 SHALL cover: Reset asserted in same cycle as MemRdy in FETCH -> IRValid=0, PC=RESET_PC, IR31_0=0 next cycle.
